sqrt_nr_seq: RTL and testbench

- Parametrised, iterative, non-restoring integer square root unit with a start/busy/done handshake.
- Computes Q = floor(sqrt(D)) and remainder = D − Q² for an unsigned DW-bit radicand, one root bit per clock.
- Optional round-to-nearest mode with saturation.
- Sits behind the datapath controller as a shared math engine; the controller owns sequencing, this block owns the iteration counter and the final remainder correction.

---
 rtl/sqrt_nr_seq.sv | 124 ++++++++++++
 tb/tb_sqrt_nr_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_nr_seq.sv
// rtl/sqrt_nr_seq.sv - iterative non-restoring integer square root, one root bit per clock
module sqrt_nr_seq #(
  parameter int DW = 16,
  parameter int QW = DW / 2,
  parameter int RW = DW / 2 + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          round,
  input  logic [DW-1:0] D,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] Q,
  output logic [QW:0]   remainder,
  output logic          sat
);

  if ((DW % 2) != 0 || DW < 4) begin : g_bad_dw
    $error("sqrt_nr_seq: DW must be even and at least 4");
  end

  localparam int IW = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state;
  logic [DW-1:0] d_reg;
  logic          rnd_reg;
  // Partial remainder in RW-bit two's complement; the MSB is the sign.
  logic [RW-1:0] r;
  logic [QW-1:0] qm;
  logic [IW-1:0] iter;

  logic [1:0]    pair;
  logic [RW-1:0] r_shift;
  logic [RW-1:0] r_calc;
  logic [RW-1:0] r_fix;
  logic [QW-1:0] qm_calc;
  logic          round_up;

  // Next-iteration remainder/root and the final sign correction and rounding decision.
  always_comb begin
    pair    = 2'(d_reg >> {iter, 1'b0});
    r_shift = {r[RW-3:0], pair};
    if (!r[RW-1]) begin
      r_calc = r_shift - {qm, 2'b01};
    end else begin
      r_calc = r_shift + {qm, 2'b11};
    end
    // The new root bit follows the sign of the freshly computed remainder.
    qm_calc  = {qm[QW-2:0], ~r_calc[RW-1]};
    r_fix    = r[RW-1] ? (r + {1'b0, qm, 1'b1}) : r;
    // Round up when the remainder exceeds Qm, i.e. D is past (Qm + 1/2)^2.
    round_up = rnd_reg && (r_fix > {2'b00, qm});
  end

  // Control FSM with the iteration datapath and registered results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat       <= 1'b0;
      Q         <= '0;
      remainder <= '0;
      d_reg     <= '0;
      rnd_reg   <= 1'b0;
      r         <= '0;
      qm        <= '0;
      iter      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            d_reg   <= D;
            rnd_reg <= round;
            r       <= '0;
            qm      <= '0;
            iter    <= IW'(QW - 1);
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          r    <= r_calc;
          qm   <= qm_calc;
          iter <= iter - 1'b1;
          if (iter == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          r         <= r_fix;
          remainder <= r_fix[QW:0];
          if (round_up) begin
            if (&qm) begin
              Q   <= qm;
              sat <= 1'b1;
            end else begin
              Q   <= qm + 1'b1;
              sat <= 1'b0;
            end
          end else begin
            Q   <= qm;
            sat <= 1'b0;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_nr_seq.sv
// tb/tb_sqrt_nr_seq.sv - directed and reference-model bench for sqrt_nr_seq at DW=8/16/32
module tb_sqrt_nr_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start16 = 0, round16 = 0, busy16, done16, sat16;
  logic [15:0] d16 = 0;
  logic [7:0]  q16;
  logic [8:0]  r16;

  logic        start8 = 0, round8 = 0, busy8, done8, sat8;
  logic [7:0]  d8 = 0;
  logic [3:0]  q8;
  logic [4:0]  r8;

  logic        start32 = 0, round32 = 0, busy32, done32, sat32;
  logic [31:0] d32 = 0;
  logic [15:0] q32;
  logic [16:0] r32;

  sqrt_nr_seq #(.DW(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .round(round16), .D(d16),
    .busy(busy16), .done(done16), .Q(q16), .remainder(r16), .sat(sat16));

  sqrt_nr_seq #(.DW(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .round(round8), .D(d8),
    .busy(busy8), .done(done8), .Q(q8), .remainder(r8), .sat(sat8));

  sqrt_nr_seq #(.DW(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .round(round32), .D(d32),
    .busy(busy32), .done(done32), .Q(q32), .remainder(r32), .sat(sat32));

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Restoring bit-by-bit integer square root, then the rounding rule.
  task automatic ref_sqrt(input longint unsigned d, input int qw, input bit rnd,
                          output longint unsigned q, output longint unsigned r, output bit s);
    longint unsigned t;
    q = 0;
    for (int b = qw - 1; b >= 0; b--) begin
      t = q | (64'd1 << b);
      if (t * t <= d) q = t;
    end
    r = d - q * q;
    s = 0;
    if (rnd && r > q) begin
      if (q == (64'd1 << qw) - 1) s = 1;
      else q = q + 1;
    end
  endtask

  // One DW=16 operation; D/round are scrambled after acceptance and a stray start hits mid-run.
  task automatic op16(input logic [15:0] d, input logic rnd,
                      output logic [7:0] q, output logic [8:0] r, output logic s,
                      output int lat, output int bc);
    @(negedge clk);
    start16 = 1; d16 = d; round16 = rnd;
    @(posedge clk);
    #1;
    start16 = 0; d16 = ~d; round16 = ~rnd;
    lat = 0; bc = 0;
    while (!done16 && lat < 100) begin
      @(negedge clk);
      lat++;
      start16 = (lat == 3);
      if (busy16) bc++;
    end
    start16 = 0;
    if (!done16) check("op16_timeout", done16, 1);
    q = q16; r = r16; s = sat16;
  endtask

  task automatic op8(input logic [7:0] d, input logic rnd, output int lat);
    @(negedge clk);
    start8 = 1; d8 = d; round8 = rnd;
    @(posedge clk);
    #1;
    start8 = 0; d8 = ~d;
    lat = 0;
    while (!done8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!done8) check("op8_timeout", done8, 1);
  endtask

  task automatic op32(input logic [31:0] d, input logic rnd, output int lat);
    @(negedge clk);
    start32 = 1; d32 = d; round32 = rnd;
    @(posedge clk);
    #1;
    start32 = 0; d32 = ~d;
    lat = 0;
    while (!done32 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!done32) check("op32_timeout", done32, 1);
  endtask

  initial begin
    logic [7:0] q; logic [8:0] r; logic s;
    int lat, bc, ndone;
    longint unsigned eq, er; bit es;
    logic [15:0] dv;
    logic [31:0] dw;

    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("rst_busy", busy16, 0);
    check("rst_done", done16, 0);
    check("rst_q", q16, 0);
    check("rst_rem", r16, 0);
    check("rst_sat", sat16, 0);

    op16(16'd144, 0, q, r, s, lat, bc);
    check("d144_latency", lat, 10);
    check("d144_busy_cycles", bc, 9);
    check("d144_q", q, 12);
    check("d144_rem", r, 0);
    check("d144_sat", s, 0);
    @(negedge clk);
    check("after_done_idle", busy16, 0);

    op16(16'd0, 0, q, r, s, lat, bc);
    check("d0_q", q, 0);
    check("d0_rem", r, 0);
    op16(16'd65535, 0, q, r, s, lat, bc);
    check("dmax_q", q, 255);
    check("dmax_rem", r, 510);
    check("dmax_sat", s, 0);

    op16(16'd150, 1, q, r, s, lat, bc);
    check("rnd150_q", q, 12);
    check("rnd150_rem", r, 6);
    op16(16'd156, 1, q, r, s, lat, bc);
    check("rnd156_q", q, 12);
    op16(16'd157, 1, q, r, s, lat, bc);
    check("rnd157_q", q, 13);
    check("rnd157_rem", r, 13);
    op16(16'd65535, 1, q, r, s, lat, bc);
    check("rndmax_q", q, 255);
    check("rndmax_sat", s, 1);
    check("rndmax_rem", r, 510);

    // Start held high: done expected in cycles 10, 21, 32, 43 after the first acceptance.
    @(negedge clk);
    start16 = 1; d16 = 16'd150; round16 = 0;
    ndone = 0;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      if (k == 44) start16 = 0;
      if (done16) begin
        check("held_done_cycle", k, 10 + 11 * ndone);
        check("held_q", q16, 12);
        ndone++;
      end
    end
    check("held_done_count", ndone, 4);
    repeat (12) @(negedge clk);

    // Async reset during the 4th CALC cycle.
    @(negedge clk);
    start16 = 1; d16 = 16'd1000;
    @(posedge clk);
    #1 start16 = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1;
    #1;
    check("abort_busy", busy16, 0);
    check("abort_done", done16, 0);
    check("abort_q", q16, 0);
    check("abort_rem", r16, 0);
    check("abort_sat", sat16, 0);
    @(negedge clk);
    reset = 0;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done16) ndone++;
    end
    check("abort_no_done", ndone, 0);
    op16(16'd81, 0, q, r, s, lat, bc);
    check("post_abort_q", q, 9);
    check("post_abort_rem", r, 0);

    // Reference sweep, DW=16.
    for (int i = 0; i < 300; i++) begin
      dv = 16'($urandom);
      for (int m = 0; m < 2; m++) begin
        op16(dv, m[0], q, r, s, lat, bc);
        ref_sqrt(64'(dv), 8, m[0], eq, er, es);
        check("sw16_latency", lat, 10);
        check("sw16_q", q, eq);
        check("sw16_rem", r, er);
        check("sw16_sat", s, es);
      end
    end

    // Exhaustive DW=8.
    for (int i = 0; i < 256; i++) begin
      for (int m = 0; m < 2; m++) begin
        op8(8'(i), m[0], lat);
        ref_sqrt(64'(i), 4, m[0], eq, er, es);
        check("sw8_latency", lat, 6);
        check("sw8_q", q8, eq);
        check("sw8_rem", r8, er);
        check("sw8_sat", sat8, es);
      end
    end

    // DW=32: corners plus random values.
    for (int i = 0; i < 64; i++) begin
      case (i)
        0: dw = 32'd0;
        1: dw = 32'hFFFF_FFFF;
        2: dw = 32'hFFFE_0001;
        3: dw = 32'hFFFE_0000;
        default: dw = $urandom;
      endcase
      for (int m = 0; m < 2; m++) begin
        op32(dw, m[0], lat);
        ref_sqrt(64'(dw), 16, m[0], eq, er, es);
        check("sw32_latency", lat, 18);
        check("sw32_q", q32, eq);
        check("sw32_rem", r32, er);
        check("sw32_sat", sat32, es);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
